// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline stage status into the hazard unit, stall/flush/forward controls out
interface pipe_hazard_ctrl_if;
    logic [4:0]  i_D_rs, i_D_rt;
    logic        i_D_isbranch, i_D_takebr, i_D_jump;
    logic [4:0]  i_E_rs, i_E_rt, i_E_rdw;
    logic        i_E_regwrite, i_E_memread;
    logic [4:0]  i_M_rdw;
    logic        i_M_regwrite, i_M_memread, i_M_memwrite;
    logic        i_mem_ack;
    logic [4:0]  i_W_rdw;
    logic        i_W_regwrite;
    logic        o_stall_F, o_stall_D, o_stall_E, o_stall_M;
    logic        o_flush_D, o_flush_E;
    logic [1:0]  o_fwd_D_rs, o_fwd_D_rt, o_fwd_E_rs, o_fwd_E_rt;
    logic        o_mem_req;
    logic [1:0]  o_state;
    logic [15:0] o_stall_cnt;
    logic        o_timeout;
    modport slave (
        input  i_D_rs, i_D_rt, i_D_isbranch, i_D_takebr, i_D_jump,
               i_E_rs, i_E_rt, i_E_rdw, i_E_regwrite, i_E_memread,
               i_M_rdw, i_M_regwrite, i_M_memread, i_M_memwrite, i_mem_ack,
               i_W_rdw, i_W_regwrite,
        output o_stall_F, o_stall_D, o_stall_E, o_stall_M, o_flush_D, o_flush_E,
               o_fwd_D_rs, o_fwd_D_rt, o_fwd_E_rs, o_fwd_E_rt,
               o_mem_req, o_state, o_stall_cnt, o_timeout
    );
    modport master (
        output i_D_rs, i_D_rt, i_D_isbranch, i_D_takebr, i_D_jump,
               i_E_rs, i_E_rt, i_E_rdw, i_E_regwrite, i_E_memread,
               i_M_rdw, i_M_regwrite, i_M_memread, i_M_memwrite, i_mem_ack,
               i_W_rdw, i_W_regwrite,
        input  o_stall_F, o_stall_D, o_stall_E, o_stall_M, o_flush_D, o_flush_E,
               o_fwd_D_rs, o_fwd_D_rt, o_fwd_E_rs, o_fwd_E_rt,
               o_mem_req, o_state, o_stall_cnt, o_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding select and memory-wait control for a 5-stage pipeline
module pipe_hazard_ctrl (
    input  logic              i_clk,
    input  logic              i_nrst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, BR = 2'd2, MWAIT = 2'd3} state_t;
    state_t      state, state_nx;
    logic [15:0] stall_cnt;
    logic [7:0]  wcnt;
    logic        timeout, lu, br, hz, freeze, redirect, m_ok, w_ok;

    function automatic logic hit(input logic [4:0] r, input logic [4:0] d);
        return (r != 5'd0) && (r == d);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r, input logic [4:0] m_rdw, input logic m_en,
                                       input logic [4:0] w_rdw, input logic w_en);
        return (m_en && hit(r, m_rdw)) ? 2'b10 : (w_en && hit(r, w_rdw)) ? 2'b01 : 2'b00;
    endfunction

    // a load in M has no result yet, so it never forwards
    assign m_ok = bus.i_M_regwrite & ~bus.i_M_memread;
    assign w_ok = bus.i_W_regwrite;
    assign bus.o_fwd_E_rs = fwd(bus.i_E_rs, bus.i_M_rdw, m_ok, bus.i_W_rdw, w_ok);
    assign bus.o_fwd_E_rt = fwd(bus.i_E_rt, bus.i_M_rdw, m_ok, bus.i_W_rdw, w_ok);
    assign bus.o_fwd_D_rs = fwd(bus.i_D_rs, bus.i_M_rdw, m_ok, bus.i_W_rdw, w_ok);
    assign bus.o_fwd_D_rt = fwd(bus.i_D_rt, bus.i_M_rdw, m_ok, bus.i_W_rdw, w_ok);

    // a branch consuming a load is tracked as br so the two-cycle wait reads BR, BR
    assign lu = bus.i_E_memread & bus.i_E_regwrite & ~bus.i_D_isbranch &
                (hit(bus.i_D_rs, bus.i_E_rdw) | hit(bus.i_D_rt, bus.i_E_rdw));
    assign br = bus.i_D_isbranch &
                ((bus.i_E_regwrite & (hit(bus.i_D_rs, bus.i_E_rdw) | hit(bus.i_D_rt, bus.i_E_rdw))) |
                 (bus.i_M_memread & (hit(bus.i_D_rs, bus.i_M_rdw) | hit(bus.i_D_rt, bus.i_M_rdw))));
    assign hz       = lu | br;
    assign redirect = bus.i_D_jump | (bus.i_D_isbranch & bus.i_D_takebr);
    assign bus.o_mem_req = bus.i_M_memread | bus.i_M_memwrite;
    assign freeze   = bus.o_mem_req & ~bus.i_mem_ack;

    assign bus.o_stall_F   = freeze | hz;
    assign bus.o_stall_D   = freeze | hz;
    assign bus.o_stall_E   = freeze;
    assign bus.o_stall_M   = freeze;
    assign bus.o_flush_E   = ~freeze & hz;
    assign bus.o_flush_D   = ~freeze & ~hz & redirect;
    assign bus.o_state     = state;
    assign bus.o_stall_cnt = stall_cnt;
    assign bus.o_timeout   = timeout;

    always_comb begin
        state_nx = freeze ? MWAIT : lu ? LU : br ? BR : RUN;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= RUN;
        else         state <= state_nx;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stall_cnt <= 16'd0;
            wcnt      <= 8'd0;
            timeout   <= 1'b0;
        end else begin
            if (bus.o_stall_F && stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
            wcnt <= !freeze ? 8'd0 : (wcnt == 8'hff) ? wcnt : wcnt + 8'd1;
            if (freeze && wcnt == 8'hff) timeout <= 1'b1;
        end
    end
endmodule
